// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU clock/interrupt/wait controller.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } wait_state_t;

    localparam int DIV_MIN     = 4;
    localparam int DIV_MAX     = 256;
    localparam int INT_LEN_MIN = 1;
    localparam int INT_LEN_MAX = 1023;
    localparam int WS_MAX      = 7;

    localparam int IC_W = 10;
    localparam int WC_W = 3;

endpackage

// File: rtl/cpu_ctl_sync.sv
// Two-flop synchroniser with rising-edge detect; edges are suppressed until the
// pipeline has refilled after reset so a level already high is not an edge.
module cpu_ctl_sync #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1_reg;
    logic [W-1:0] s2_reg;
    logic [W-1:0] s3_reg;
    logic [1:0]   prime_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prime_reg <= 2'd0;
        end else if (prime_reg != 2'd3) begin
            prime_reg <= prime_reg + 2'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    s1_reg[gi] <= 1'b0;
                    s2_reg[gi] <= 1'b0;
                    s3_reg[gi] <= 1'b0;
                end else begin
                    s1_reg[gi] <= d[gi];
                    s2_reg[gi] <= s1_reg[gi];
                    s3_reg[gi] <= s2_reg[gi];
                end
            end

            assign rise[gi] = s2_reg[gi] && !s3_reg[gi] && (prime_reg == 2'd3);
        end
    endgenerate

endmodule

// File: rtl/cpu_ctl.sv
// CPU clock-enable generator with vsync interrupt timing and bus wait-state
// insertion; all counters advance on cep so pause freezes everything.
module cpu_ctl
    import cpu_pkg::*;
#(
    parameter int DIV     = 8,
    parameter int INT_LEN = 64,
    parameter int WS_MEM  = 1,
    parameter int WS_IO   = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic pause,
    input  logic turbo,
    input  logic vsync,
    input  logic slow,
    input  logic mreq_n,
    input  logic iorq_n,
    input  logic m1_n,
    output logic cep,
    output logic cen,
    output logic int_n,
    output logic wait_n
);

    localparam int PH_W = $clog2(DIV);

    logic [PH_W-1:0] ph_reg;
    logic            turbo_reg;
    logic [PH_W-1:0] ph_last;
    logic [PH_W-1:0] ph_half;

    // turbo is only taken at the wrap so a T-state never changes length midway
    assign ph_last = turbo_reg ? PH_W'(DIV/2 - 1) : PH_W'(DIV - 1);
    assign ph_half = turbo_reg ? PH_W'(DIV/4 - 1) : PH_W'(DIV/2 - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph_reg    <= '0;
            turbo_reg <= 1'b0;
        end else if (!pause) begin
            if (ph_reg == ph_last) begin
                ph_reg    <= '0;
                turbo_reg <= turbo;
            end else begin
                ph_reg <= ph_reg + PH_W'(1);
            end
        end
    end

    assign cep = !pause && (ph_reg == ph_last);
    assign cen = !pause && (ph_reg == ph_half);

    logic [0:0] vs_rise;

    cpu_ctl_sync #(.W(1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (vsync),
        .rise  (vs_rise)
    );

    logic            int_n_reg;
    logic [IC_W-1:0] ic_reg;
    logic            ack;
    logic            int_release;

    assign ack         = !m1_n && !iorq_n;
    assign int_release = !int_n_reg && (ack || (cep && ic_reg == IC_W'(1)));

    // A new edge beats a release in the same clock; otherwise edges are dropped while low
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            int_n_reg <= 1'b1;
            ic_reg    <= '0;
        end else if (vs_rise[0] && (int_n_reg || int_release)) begin
            int_n_reg <= 1'b0;
            ic_reg    <= IC_W'(INT_LEN);
        end else if (int_release) begin
            int_n_reg <= 1'b1;
            ic_reg    <= '0;
        end else if (!int_n_reg && cep) begin
            ic_reg <= ic_reg - IC_W'(1);
        end
    end

    assign int_n = int_n_reg;

    wait_state_t     state_reg, state_next;
    logic [WC_W-1:0] wc_reg, wc_next;
    logic            mreq_q_reg, iorq_q_reg;
    logic            io_fall, mem_fall, io_start, mem_start;
    logic [WC_W-1:0] n_start;

    assign io_fall   = !iorq_n && iorq_q_reg;
    assign mem_fall  = !mreq_n && mreq_q_reg;
    assign io_start  = io_fall && m1_n;
    assign mem_start = mem_fall && slow && !io_fall;
    assign n_start   = io_start ? WC_W'(WS_IO) : WC_W'(WS_MEM);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            wc_reg     <= '0;
            mreq_q_reg <= 1'b1;
            iorq_q_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            wc_reg     <= wc_next;
            mreq_q_reg <= mreq_n;
            iorq_q_reg <= iorq_n;
        end
    end

    always_comb begin
        state_next = state_reg;
        wc_next    = wc_reg;
        case (state_reg)
            ST_IDLE: begin
                if (io_start || mem_start) begin
                    wc_next    = n_start;
                    state_next = (n_start == '0) ? ST_HOLD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cep) begin
                    if (wc_reg == WC_W'(1)) begin
                        wc_next    = '0;
                        state_next = ST_HOLD;
                    end else begin
                        wc_next = wc_reg - WC_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (mreq_n && iorq_n) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                wc_next    = '0;
            end
        endcase
    end

    assign wait_n = (state_reg != ST_WAIT);

endmodule
